// File: rtl/fpu_req_arbiter_if.sv
// Requester/core bundle for fpu_req_arbiter: one operation in flight, result held until the owner acks.
// The arbiter uses the slave modport; requesters and the core model sit on the master side.
interface fpu_req_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int DW      = 32,
  parameter int OPW     = 4
);
  logic [NUM_REQ-1:0]     req_valid;
  logic [NUM_REQ*OPW-1:0] req_op;
  logic [NUM_REQ*DW-1:0]  req_a;
  logic [NUM_REQ*DW-1:0]  req_b;
  logic [NUM_REQ-1:0]     req_grant;
  logic [NUM_REQ-1:0]     rsp_valid;
  logic [DW-1:0]          rsp_result;
  logic                   rsp_err;
  logic [NUM_REQ-1:0]     rsp_ack;
  logic                   fpu_start;
  logic [OPW-1:0]         fpu_op;
  logic [DW-1:0]          fpu_a;
  logic [DW-1:0]          fpu_b;
  logic                   fpu_done;
  logic [DW-1:0]          fpu_result;
  logic                   arb_busy;
  logic [1:0]             arb_owner;

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ack, fpu_done, fpu_result,
    output req_grant, rsp_valid, rsp_result, rsp_err,
    output fpu_start, fpu_op, fpu_a, fpu_b, arb_busy, arb_owner
  );

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ack, fpu_done, fpu_result,
    input  req_grant, rsp_valid, rsp_result, rsp_err,
    input  fpu_start, fpu_op, fpu_a, fpu_b, arb_busy, arb_owner
  );
endinterface

// File: rtl/fpu_req_arbiter.sv
// Round-robin sharing of one FPU core: grant+start one cycle after req_valid, result from the cycle after fpu_done,
// held until the owner acks (no new grant meanwhile). FPU_ARB_TIMEOUT_EN adds a TIMEOUT_CYC watchdog on WAIT.
module fpu_req_arbiter #(
  parameter int NUM_REQ     = 2,
  parameter int DW          = 32,
  parameter int OPW         = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input logic               clk,
  input logic               arst_n,
  fpu_req_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [OPW-1:0]     OP_LAST = OPW'(4'hA);
  localparam logic [DW-1:0]      QNAN    = DW'(32'h7FC0_0000);
  localparam logic [NUM_REQ-1:0] ONE     = NUM_REQ'(1);
  localparam logic [1:0]         RR_INIT = 2'(NUM_REQ - 1);

  if (NUM_REQ < 1 || NUM_REQ > 4 || TIMEOUT_CYC < 1) begin : g_param_err
    $error("fpu_req_arbiter: NUM_REQ must be 1..4 and TIMEOUT_CYC >= 1");
  end

  state_t             state;
  logic [1:0]         rr;
  logic [1:0]         owner_q;
  logic [OPW-1:0]     op_q;
  logic [DW-1:0]      a_q;
  logic [DW-1:0]      b_q;
  logic [NUM_REQ-1:0] grant_q;
  logic [NUM_REQ-1:0] rsp_vld_q;
  logic [DW-1:0]      result_q;
  logic               err_q;
  logic               start_q;
  logic               busy_q;

  logic               win_vld;
  logic [1:0]         win_idx;
  logic [OPW-1:0]     win_op;
  logic [DW-1:0]      win_a;
  logic [DW-1:0]      win_b;
  logic               owner_ack;

`ifdef FPU_ARB_TIMEOUT_EN
  localparam int            TO_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
  logic [TO_W-1:0] to_cnt;
`endif

  // Walk downward so the closest requester after rr is the last one assigned.
  always_comb begin
    int idx;
    idx     = 0;
    win_vld = 1'b0;
    win_idx = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      idx = (int'(rr) + i) % NUM_REQ;
      if (bus.req_valid[idx]) begin
        win_vld = 1'b1;
        win_idx = 2'(idx);
      end
    end
  end

  assign win_op    = bus.req_op[int'(win_idx)*OPW +: OPW];
  assign win_a     = bus.req_a[int'(win_idx)*DW +: DW];
  assign win_b     = bus.req_b[int'(win_idx)*DW +: DW];
  assign owner_ack = |(bus.rsp_ack & rsp_vld_q);

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state     <= IDLE;
      rr        <= RR_INIT;
      owner_q   <= '0;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      grant_q   <= '0;
      rsp_vld_q <= '0;
      result_q  <= '0;
      err_q     <= 1'b0;
      start_q   <= 1'b0;
      busy_q    <= 1'b0;
`ifdef FPU_ARB_TIMEOUT_EN
      to_cnt    <= '0;
`endif
    end else begin
      grant_q <= '0;
      start_q <= 1'b0;
      case (state)
        IDLE: begin
          if (win_vld) begin
            state   <= ISSUE;
            busy_q  <= 1'b1;
            owner_q <= win_idx;
            op_q    <= win_op;
            a_q     <= win_a;
            b_q     <= win_b;
            grant_q <= ONE << win_idx;
            start_q <= (win_op <= OP_LAST);
          end
        end
        ISSUE: begin
          // start_q being high in ISSUE is exactly the legal-op decision.
          if (start_q) begin
            state  <= WAIT;
`ifdef FPU_ARB_TIMEOUT_EN
            to_cnt <= '0;
`endif
          end else begin
            state     <= RESP;
            result_q  <= QNAN;
            err_q     <= 1'b1;
            rsp_vld_q <= ONE << owner_q;
          end
        end
        WAIT: begin
          if (bus.fpu_done) begin
            state     <= RESP;
            result_q  <= bus.fpu_result;
            err_q     <= 1'b0;
            rsp_vld_q <= ONE << owner_q;
          end
`ifdef FPU_ARB_TIMEOUT_EN
          else if (to_cnt == TO_LAST) begin
            state     <= RESP;
            result_q  <= QNAN;
            err_q     <= 1'b1;
            rsp_vld_q <= ONE << owner_q;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
`endif
        end
        RESP: begin
          if (owner_ack) begin
            state     <= IDLE;
            busy_q    <= 1'b0;
            rsp_vld_q <= '0;
            rr        <= owner_q;
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_grant  = grant_q;
  assign bus.rsp_valid  = rsp_vld_q;
  assign bus.rsp_result = result_q;
  assign bus.rsp_err    = err_q;
  assign bus.fpu_start  = start_q;
  assign bus.fpu_op     = op_q;
  assign bus.fpu_a      = a_q;
  assign bus.fpu_b      = b_q;
  assign bus.arb_busy   = busy_q;
  assign bus.arb_owner  = owner_q;

  a_grant_onehot: assert property (@(posedge clk) disable iff (!arst_n) $onehot0(grant_q));
  a_rsp_onehot:   assert property (@(posedge clk) disable iff (!arst_n) $onehot0(rsp_vld_q));
  a_start_grant:  assert property (@(posedge clk) disable iff (!arst_n) start_q |-> (|grant_q));

endmodule
